nkmm_dspc_memloader: RTL

//   Write-side companion of the DSP core's 4-bank operand memories (mpcand/mplier banks 0..3).

---
 rtl/nkmm_dspc_memloader_if.sv | 47 ++++
 rtl/nkmm_dspc_memloader.sv | 138 +++++++++++++
 2 files changed

// File: rtl/nkmm_dspc_memloader_if.sv
`default_nettype none
// ============================================================================
//  Module   : nkmm_dspc_memloader_if
//  Purpose  : Command, sample-stream and bank-write bus of the operand
//             memory loader. The slave modport is the loader's view; the
//             master modport is the view of the block that drives it.
//  Revision : 1.0  initial release
// ============================================================================
interface nkmm_dspc_memloader_if #(
  parameter int AW = 12,
  parameter int DW = 24
) ();
  // load command
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [AW-1:0] cmd_base_i;
  logic [AW+1:0] cmd_count_i;
  logic [AW-1:0] cmd_mask_i;
  logic          abort_i;
  // sample / coefficient stream
  logic          s_valid_i;
  logic          s_ready_o;
  logic [DW-1:0] s_data_i;
  logic          hold_i;
  // bank write port and status
  logic          wr_en_o;
  logic [1:0]    wr_bank_o;
  logic [AW-1:0] wr_addr_o;
  logic [DW-1:0] wr_data_o;
  logic          busy_o;
  logic          done_o;

  modport slave (
    input  cmd_valid_i, cmd_base_i, cmd_count_i, cmd_mask_i, abort_i,
    input  s_valid_i, s_data_i, hold_i,
    output cmd_ready_o, s_ready_o,
    output wr_en_o, wr_bank_o, wr_addr_o, wr_data_o, busy_o, done_o
  );

  modport master (
    output cmd_valid_i, cmd_base_i, cmd_count_i, cmd_mask_i, abort_i,
    output s_valid_i, s_data_i, hold_i,
    input  cmd_ready_o, s_ready_o,
    input  wr_en_o, wr_bank_o, wr_addr_o, wr_data_o, busy_o, done_o
  );
endinterface
`default_nettype wire

// File: rtl/nkmm_dspc_memloader.sv
`default_nettype none
// ============================================================================
//  Module   : nkmm_dspc_memloader
//  Purpose  : Loads a 24-bit word stream into the DSP core's 4-bank operand
//             memories. Words are interleaved over banks 0..3; after bank 3
//             the bank address takes the same masked increment the core's
//             read address generator uses.
//  Revision : 1.0  initial release
// ============================================================================
module nkmm_dspc_memloader #(
  parameter int AW = 12,
  parameter int DW = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  nkmm_dspc_memloader_if.slave  bus
);

  localparam int c_CW = AW + 2;

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_LOAD = 1'b1;

  localparam logic [c_CW-1:0] c_CNT_ONE  = {{(c_CW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]   c_ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [1:0]      c_LAST_BANK = 2'd3;

  // load context
  logic [0:0]      r_state;
  logic [AW-1:0]   r_addr;
  logic [AW-1:0]   r_mask;
  logic [1:0]      r_bank;
  logic [c_CW-1:0] r_remaining;

  // registered write port
  logic            r_wr_en;
  logic [1:0]      r_wr_bank;
  logic [AW-1:0]   r_wr_addr;
  logic [DW-1:0]   r_wr_data;
  logic            r_done;

  logic            w_cmd_ready;
  logic            w_s_ready;
  logic            w_cmd_fire;
  logic            w_cmd_empty;
  logic            w_accept;
  logic            w_last;
  logic [AW-1:0]   w_addr_inc;
  logic [AW-1:0]   w_addr_next;

  // Both ready outputs are forced low while reset is held so nothing is
  // taken in on the reset edge. Abort and hold block the stream directly,
  // which guarantees no word is consumed in an abort cycle.
  assign w_cmd_ready = ~rst & (r_state == c_ST_IDLE);
  assign w_s_ready   = ~rst & (r_state == c_ST_LOAD) & ~bus.hold_i & ~bus.abort_i;

  assign w_cmd_fire  = bus.cmd_valid_i & w_cmd_ready;
  assign w_cmd_empty = (bus.cmd_count_i == '0);
  assign w_accept    = bus.s_valid_i & w_s_ready;
  assign w_last      = w_accept & (r_remaining == c_CNT_ONE);

  // Only the bits selected by the mask may change; the carry out of the
  // top bit is simply lost, giving circular addressing inside the block.
  assign w_addr_inc  = r_addr + c_ADDR_ONE;
  assign w_addr_next = (r_addr & ~r_mask) | (w_addr_inc & r_mask);

  // Load sequencing: command latch, bank/address stepping, word countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_ST_IDLE;
      r_addr      <= '0;
      r_mask      <= '0;
      r_bank      <= 2'd0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_cmd_fire) begin
            r_addr      <= bus.cmd_base_i;
            r_mask      <= bus.cmd_mask_i;
            r_bank      <= 2'd0;
            r_remaining <= bus.cmd_count_i;
            if (!w_cmd_empty) begin
              r_state <= c_ST_LOAD;
            end
          end
        end
        c_ST_LOAD: begin
          if (bus.abort_i) begin
            r_state <= c_ST_IDLE;
          end else if (w_accept) begin
            r_bank      <= r_bank + 2'd1;
            r_remaining <= r_remaining - c_CNT_ONE;
            if (r_bank == c_LAST_BANK) begin
              r_addr <= w_addr_next;
            end
            if (r_remaining == c_CNT_ONE) begin
              r_state <= c_ST_IDLE;
            end
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  // Write port: one registered bank write per accepted word, plus the
  // completion pulse aligned with the final write (or one cycle after an
  // empty command).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_bank <= 2'd0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_done    <= 1'b0;
    end else begin
      r_wr_en <= w_accept;
      r_done  <= w_last | (w_cmd_fire & w_cmd_empty);
      if (w_accept) begin
        r_wr_bank <= r_bank;
        r_wr_addr <= r_addr;
        r_wr_data <= bus.s_data_i;
      end
    end
  end

  assign bus.cmd_ready_o = w_cmd_ready;
  assign bus.s_ready_o   = w_s_ready;
  assign bus.wr_en_o     = r_wr_en;
  assign bus.wr_bank_o   = r_wr_bank;
  assign bus.wr_addr_o   = r_wr_addr;
  assign bus.wr_data_o   = r_wr_data;
  assign bus.busy_o      = (r_state == c_ST_LOAD);
  assign bus.done_o      = r_done;

endmodule
`default_nettype wire
